// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline control blocks: FSM states and the
// scoreboard entry that follows each instruction from EX to WB.
package mips_pkg;

  localparam int REG_W_DEFAULT = 5;
  // Scoreboard destinations are stored at a fixed width so the struct can
  // live here; narrower register addresses are zero-extended on the way in.
  localparam int REG_W_MAX = 8;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [REG_W_MAX-1:0] dest;
    logic                 load;
  } sb_entry_t;

  localparam int SB_W = $bits(sb_entry_t);

endpackage

// File: rtl/hazard_match.sv
// Compares one decode source register against every in-flight scoreboard
// entry; returns the per-entry hit vector and the youngest-writer select.
module hazard_match
  import mips_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int REG_W  = REG_W_DEFAULT,
  parameter int SEL_W  = $clog2(STAGES + 1)
) (
  input  logic [REG_W-1:0]       src_i,
  input  logic                   use_i,
  input  logic [STAGES*SB_W-1:0] entries_i,
  output logic [STAGES-1:0]      hit_o,
  output logic [SEL_W-1:0]       sel_o
);

  sb_entry_t [STAGES-1:0] ents;
  logic      [STAGES-1:0] hit;

  assign ents = entries_i;

  always_comb begin
    hit   = '0;
    sel_o = '0;
    for (int i = 0; i < STAGES; i++) begin
      hit[i] = use_i && (src_i != '0) && ents[i].valid && ents[i].wr &&
               (ents[i].dest == REG_W_MAX'(src_i));
    end
    // Scan oldest to youngest so the youngest writer is the last one kept.
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (hit[i]) sel_o = SEL_W'(i + 1);
    end
  end

  assign hit_o = hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and fetch-sequencing controller: tracks in-flight writers,
// drives forwarding selects, and stalls/refills fetch and decode.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int REG_W  = REG_W_DEFAULT,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16,
  localparam int SEL_W = $clog2(STAGES + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             dec_valid_i,
  input  logic [REG_W-1:0] dec_rs_i,
  input  logic [REG_W-1:0] dec_rt_i,
  input  logic             dec_use_rs_i,
  input  logic             dec_use_rt_i,
  input  logic             dec_wr_i,
  input  logic [REG_W-1:0] dec_dest_i,
  input  logic             dec_load_i,
  input  logic             redirect_i,
  output logic             pc_en_o,
  output logic             pc_redirect_o,
  output logic             dec_en_o,
  output logic             dec_flush_o,
  output logic             ex_bubble_o,
  output logic [SEL_W-1:0] fwd_a_o,
  output logic [SEL_W-1:0] fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Entries that still need a stall without forwarding; WB writes in time.
  localparam logic [STAGES-1:0] PRE_WB_MASK = {1'b0, {(STAGES-1){1'b1}}};

  state_e                 state_q, state_d;
  sb_entry_t [STAGES-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [STAGES-1:0]      hit_a, hit_b;
  logic [SEL_W-1:0]       sel_a, sel_b;
  logic                   hazard, issue, stall_evt, flush_evt;

  hazard_match #(.STAGES(STAGES), .REG_W(REG_W), .SEL_W(SEL_W)) u_match_rs (
    .src_i     (dec_rs_i),
    .use_i     (dec_use_rs_i),
    .entries_i (sb_q),
    .hit_o     (hit_a),
    .sel_o     (sel_a)
  );

  hazard_match #(.STAGES(STAGES), .REG_W(REG_W), .SEL_W(SEL_W)) u_match_rt (
    .src_i     (dec_rt_i),
    .use_i     (dec_use_rt_i),
    .entries_i (sb_q),
    .hit_o     (hit_b),
    .sel_o     (sel_b)
  );

  always_comb begin
    hazard = dec_valid_i &&
             (((hit_a[0] || hit_b[0]) && sb_q[0].load) ||
              ((FWD_EN == 0) && (|((hit_a | hit_b) & PRE_WB_MASK))));
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // through the case leaves it unassigned and infers a latch.
    state_d       = state_q;
    pc_en_o       = 1'b0;
    pc_redirect_o = 1'b0;
    dec_en_o      = 1'b0;
    dec_flush_o   = 1'b0;
    ex_bubble_o   = 1'b1;
    issue         = 1'b0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;
    if (reset_i) begin
      dec_flush_o = 1'b1;
      state_d     = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL: begin
          pc_en_o  = 1'b1;
          dec_en_o = 1'b1;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          if (redirect_i && sb_q[0].valid) begin
            pc_en_o       = 1'b1;
            pc_redirect_o = 1'b1;
            dec_flush_o   = 1'b1;
            flush_evt     = 1'b1;
            state_d       = ST_FILL;
          end else if (hazard) begin
            stall_evt = 1'b1;
          end else begin
            pc_en_o     = 1'b1;
            dec_en_o    = 1'b1;
            ex_bubble_o = 1'b0;
            issue       = dec_valid_i;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_comb begin
    sb_d    = '0;
    if (issue) begin
      sb_d[0].valid = 1'b1;
      sb_d[0].wr    = dec_wr_i;
      sb_d[0].dest  = REG_W_MAX'(dec_dest_i);
      sb_d[0].load  = dec_load_i;
    end
    for (int i = 1; i < STAGES; i++) sb_d[i] = sb_q[i-1];
    stall_cnt_d = (stall_evt && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush_evt && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  always_ff @(posedge clock_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q     <= ST_FILL;
      sb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a_o     = ((FWD_EN != 0) && dec_valid_i && !reset_i) ? sel_a : '0;
  assign fwd_b_o     = ((FWD_EN != 0) && dec_valid_i && !reset_i) ? sel_b : '0;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations (forwarding, no forwarding,
// 2-bit counters) share one stimulus stream, checked against an issue-history model.
module tb_pipe_hazard_ctrl;

  localparam int STAGES = 3;
  localparam int NDUT   = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, dec_valid, dec_use_rs, dec_use_rt, dec_wr, dec_load, redirect;
  logic [4:0] dec_rs, dec_rt, dec_dest;

  logic       pc_en[NDUT], pc_redirect[NDUT], dec_en[NDUT], dec_flush[NDUT], ex_bubble[NDUT];
  logic [1:0] fwd_a[NDUT], fwd_b[NDUT];
  logic [15:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
  logic [1:0]  stall_cnt2, flush_cnt2;

  pipe_hazard_ctrl #(.STAGES(STAGES), .REG_W(5), .FWD_EN(1), .CNT_W(16)) dut_fwd (
    .clock_i(clock), .reset_i(reset), .dec_valid_i(dec_valid), .dec_rs_i(dec_rs), .dec_rt_i(dec_rt),
    .dec_use_rs_i(dec_use_rs), .dec_use_rt_i(dec_use_rt), .dec_wr_i(dec_wr), .dec_dest_i(dec_dest),
    .dec_load_i(dec_load), .redirect_i(redirect), .pc_en_o(pc_en[0]), .pc_redirect_o(pc_redirect[0]),
    .dec_en_o(dec_en[0]), .dec_flush_o(dec_flush[0]), .ex_bubble_o(ex_bubble[0]),
    .fwd_a_o(fwd_a[0]), .fwd_b_o(fwd_b[0]), .stall_cnt_o(stall_cnt0), .flush_cnt_o(flush_cnt0));

  pipe_hazard_ctrl #(.STAGES(STAGES), .REG_W(5), .FWD_EN(0), .CNT_W(16)) dut_nofwd (
    .clock_i(clock), .reset_i(reset), .dec_valid_i(dec_valid), .dec_rs_i(dec_rs), .dec_rt_i(dec_rt),
    .dec_use_rs_i(dec_use_rs), .dec_use_rt_i(dec_use_rt), .dec_wr_i(dec_wr), .dec_dest_i(dec_dest),
    .dec_load_i(dec_load), .redirect_i(redirect), .pc_en_o(pc_en[1]), .pc_redirect_o(pc_redirect[1]),
    .dec_en_o(dec_en[1]), .dec_flush_o(dec_flush[1]), .ex_bubble_o(ex_bubble[1]),
    .fwd_a_o(fwd_a[1]), .fwd_b_o(fwd_b[1]), .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1));

  pipe_hazard_ctrl #(.STAGES(STAGES), .REG_W(5), .FWD_EN(1), .CNT_W(2)) dut_cnt2 (
    .clock_i(clock), .reset_i(reset), .dec_valid_i(dec_valid), .dec_rs_i(dec_rs), .dec_rt_i(dec_rt),
    .dec_use_rs_i(dec_use_rs), .dec_use_rt_i(dec_use_rt), .dec_wr_i(dec_wr), .dec_dest_i(dec_dest),
    .dec_load_i(dec_load), .redirect_i(redirect), .pc_en_o(pc_en[2]), .pc_redirect_o(pc_redirect[2]),
    .dec_en_o(dec_en[2]), .dec_flush_o(dec_flush[2]), .ex_bubble_o(ex_bubble[2]),
    .fwd_a_o(fwd_a[2]), .fwd_b_o(fwd_b[2]), .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2));

  // Reference model: a log of what issued on each cycle. An instruction that
  // issued on cycle t sits in pipeline slot (now - t - 1) during cycle now.
  typedef struct packed {
    logic       v;
    logic       wr;
    logic [4:0] dest;
    logic       ld;
  } ins_t;

  ins_t        hist[NDUT][8];
  int          cyc;
  bit          in_fill[NDUT];
  int unsigned scnt[NDUT], fcnt[NDUT];
  bit          m_take[NDUT], m_iss[NDUT], m_stall[NDUT];
  int          checks, errors;

  function automatic bit fwd_on(int d);
    return d != 1;
  endfunction

  function automatic int unsigned cnt_max(int d);
    return (d == 2) ? 3 : 65535;
  endfunction

  function automatic logic [15:0] act_scnt(int d);
    case (d)
      0:       return stall_cnt0;
      1:       return stall_cnt1;
      default: return {14'b0, stall_cnt2};
    endcase
  endfunction

  function automatic logic [15:0] act_fcnt(int d);
    case (d)
      0:       return flush_cnt0;
      1:       return flush_cnt1;
      default: return {14'b0, flush_cnt2};
    endcase
  endfunction

  function automatic ins_t slot(int d, int k);
    ins_t e;
    e = hist[d][(cyc - 1 - k) & 7];
    return e;
  endfunction

  function automatic bit hit(int d, int k, logic [4:0] src, logic use_src);
    ins_t e;
    e = slot(d, k);
    return use_src && (src != 5'd0) && e.v && e.wr && (e.dest == src);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int j = 0; j < 8; j++) hist[d][j] = '0;
      in_fill[d] = 1'b1;
      scnt[d]    = 0;
      fcnt[d]    = 0;
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic wr, input logic [4:0] dest,
                      input logic ld, input logic redir);
    reset = rst; dec_valid = v; dec_rs = rs; dec_rt = rt; dec_use_rs = urs; dec_use_rt = urt;
    dec_wr = wr; dec_dest = dest; dec_load = ld; redirect = redir;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      ins_t       e0;
      bit         haz, raw;
      bit         e_pc, e_red, e_den, e_fl, e_bub;
      logic [1:0] fa, fb;
      e0 = slot(d, 0);
      fa = 2'd0;
      fb = 2'd0;
      if (fwd_on(d) && v && !rst) begin
        for (int k = STAGES - 1; k >= 0; k--) begin
          if (hit(d, k, rs, urs)) fa = 2'(k + 1);
          if (hit(d, k, rt, urt)) fb = 2'(k + 1);
        end
      end
      raw = 1'b0;
      if (!fwd_on(d))
        for (int k = 0; k < STAGES - 1; k++) raw = raw | hit(d, k, rs, urs) | hit(d, k, rt, urt);
      haz = v && (((hit(d, 0, rs, urs) || hit(d, 0, rt, urt)) && e0.ld) || raw);
      m_take[d] = 1'b0; m_iss[d] = 1'b0; m_stall[d] = 1'b0;
      if (rst)                     {e_pc, e_red, e_den, e_fl, e_bub} = 5'b00011;
      else if (in_fill[d])         {e_pc, e_red, e_den, e_fl, e_bub} = 5'b10101;
      else if (redir && e0.v) begin {e_pc, e_red, e_den, e_fl, e_bub} = 5'b11011; m_take[d] = 1'b1; end
      else if (haz)          begin {e_pc, e_red, e_den, e_fl, e_bub} = 5'b00001; m_stall[d] = 1'b1; end
      else                   begin {e_pc, e_red, e_den, e_fl, e_bub} = 5'b10100; m_iss[d] = v; end
      check($sformatf("d%0d pc_en", d), 32'(pc_en[d]), 32'(e_pc));
      check($sformatf("d%0d pc_redirect", d), 32'(pc_redirect[d]), 32'(e_red));
      check($sformatf("d%0d dec_en", d), 32'(dec_en[d]), 32'(e_den));
      check($sformatf("d%0d dec_flush", d), 32'(dec_flush[d]), 32'(e_fl));
      check($sformatf("d%0d ex_bubble", d), 32'(ex_bubble[d]), 32'(e_bub));
      check($sformatf("d%0d fwd_a", d), 32'(fwd_a[d]), 32'(fa));
      check($sformatf("d%0d fwd_b", d), 32'(fwd_b[d]), 32'(fb));
      check($sformatf("d%0d stall_cnt", d), 32'(act_scnt(d)), scnt[d]);
      check($sformatf("d%0d flush_cnt", d), 32'(act_fcnt(d)), fcnt[d]);
    end
    @(posedge clock);
    if (rst) begin
      model_reset();
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        hist[d][cyc & 7] = m_iss[d] ? {1'b1, wr, dest, ld} : ins_t'('0);
        in_fill[d] = in_fill[d] ? 1'b0 : m_take[d];
        if (m_stall[d] && scnt[d] < cnt_max(d)) scnt[d]++;
        if (m_take[d] && fcnt[d] < cnt_max(d)) fcnt[d]++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    step(1'b0, 1'b1, rs, rt, 1'b1, 1'b1, 1'b1, rd, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] base, input logic [4:0] rd);
    step(1'b0, 1'b1, base, 5'd0, 1'b1, 1'b0, 1'b1, rd, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    model_reset();
    reset = 1'b1; dec_valid = 1'b0; dec_rs = '0; dec_rt = '0; dec_use_rs = 1'b0; dec_use_rt = 1'b0;
    dec_wr = 1'b0; dec_dest = '0; dec_load = 1'b0; redirect = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset values, release into FILL, then independent ALU ops.
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    nop();
    alu(5'd1, 5'd2, 5'd7); alu(5'd8, 5'd9, 5'd10); alu(5'd11, 5'd12, 5'd13); alu(5'd14, 5'd15, 5'd16);

    // Back-to-back RAW, one-gap RAW, and a $0 destination.
    alu(5'd1, 5'd2, 5'd3); alu(5'd3, 5'd1, 5'd4); nop(); nop(); nop();
    alu(5'd1, 5'd2, 5'd3); nop(); alu(5'd3, 5'd1, 5'd4); nop(); nop();
    alu(5'd1, 5'd2, 5'd0); alu(5'd0, 5'd1, 5'd4); nop(); nop();

    // Load-use: one stall, then the held consumer forwards from slot 2.
    lw(5'd1, 5'd5); alu(5'd5, 5'd2, 5'd6); alu(5'd5, 5'd2, 5'd6); nop(); nop();

    // Redirect arriving during a load-use stall, followed by FILL.
    lw(5'd1, 5'd6);
    step(1'b0, 1'b1, 5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1);
    nop(); nop(); nop();

    // Stall saturation on the 2-bit counter instance.
    for (int n = 0; n < 5; n++) begin
      lw(5'd1, 5'd5); alu(5'd2, 5'd5, 5'd6); alu(5'd2, 5'd5, 5'd6); nop(); nop();
    end

    // Reset asserted in the middle of a stall.
    lw(5'd1, 5'd5);
    step(1'b1, 1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    nop();

    // Randomized traffic over a small register pool to provoke matches.
    for (int n = 0; n < 400; n++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 99) == 0), v,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           v & 1'($urandom), v & 1'($urandom), v & 1'($urandom),
           5'($urandom_range(0, 3)), v & ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
